// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo arm sequencer.
// Defaults target a 100 MHz clock with a standard 50 Hz hobby-servo frame.
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        RETURN,
        DONE,
        WAIT_REL
    } state_e;

    localparam logic PICK = 1'b0;
    localparam logic DROP = 1'b1;

    localparam int unsigned DEF_PERIOD_CYC = 2_000_000;
    localparam int unsigned DEF_W_NEUTRAL  = 150_000;
    localparam int unsigned DEF_W_PICK     = 100_000;
    localparam int unsigned DEF_W_DROP     = 200_000;
    localparam int unsigned DEF_ACT_FRAMES = 50;
    localparam int unsigned DEF_RET_FRAMES = 50;
    localparam int unsigned DEF_CNT_W      = 21;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Free-running servo PWM frame generator; the requested width is adopted
// only at frame boundaries so a pulse is never reshaped mid-frame.
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYC = 2_000_000,
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned W_RST      = 150_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] width_req,
    output logic             pwm,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] WIDTH_RST = CNT_W'(W_RST);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_cur_q, width_cur_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        frame_end   = (cnt_q == CNT_LAST);
        cnt_d       = frame_end ? '0 : cnt_q + 1'b1;
        width_cur_d = frame_end ? width_req : width_cur_q;
        // One cycle behind the counter, so every frame (including the
        // first after reset) carries exactly width_cur high cycles.
        pwm_d       = (cnt_q < width_cur_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            width_cur_q <= WIDTH_RST;
            pwm_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            width_cur_q <= width_cur_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_sequencer.sv
// Servo handshake responder: runs a pickup/dropoff arm routine on request,
// then strobes servo_done and waits for the request to be released.
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned W_NEUTRAL  = DEF_W_NEUTRAL,
    parameter int unsigned W_PICK     = DEF_W_PICK,
    parameter int unsigned W_DROP     = DEF_W_DROP,
    parameter int unsigned ACT_FRAMES = DEF_ACT_FRAMES,
    parameter int unsigned RET_FRAMES = DEF_RET_FRAMES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic servo_EN,
    input  logic servo_state,
    output logic pwm,
    output logic servo_done,
    output logic busy
);

    localparam int unsigned FRM_W = $clog2(max_u(ACT_FRAMES, RET_FRAMES) + 1);

    localparam logic [CNT_W-1:0] WN = CNT_W'(W_NEUTRAL);
    localparam logic [CNT_W-1:0] WP = CNT_W'(W_PICK);
    localparam logic [CNT_W-1:0] WD = CNT_W'(W_DROP);
    localparam logic [FRM_W-1:0] ACT_LAST = FRM_W'(ACT_FRAMES);
    localparam logic [FRM_W-1:0] RET_LAST = FRM_W'(RET_FRAMES);

    if ((W_NEUTRAL >= PERIOD_CYC) || (W_PICK >= PERIOD_CYC) || (W_DROP >= PERIOD_CYC) ||
        ((64'(1) << CNT_W) <= 64'(PERIOD_CYC))) begin : g_cfg_err
        $error("servo_sequencer: pulse widths must be below PERIOD_CYC and PERIOD_CYC must fit in CNT_W");
    end

    state_e           state_q, state_d;
    logic [FRM_W-1:0] frm_q, frm_d, frm_inc;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] width_req_q, width_req_d;
    logic             frame_end;

    servo_pwm_gen #(
        .PERIOD_CYC(PERIOD_CYC),
        .CNT_W     (CNT_W),
        .W_RST     (W_NEUTRAL)
    ) u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .width_req(width_req_q),
        .pwm      (pwm),
        .frame_end(frame_end)
    );

    always_comb begin
        state_d     = state_q;
        frm_d       = frm_q;
        dir_d       = dir_q;
        width_req_d = width_req_q;
        frm_inc     = frm_q + 1'b1;
        servo_done  = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                width_req_d = WN;
                if (servo_EN) begin
                    dir_d       = servo_state;
                    width_req_d = (servo_state == DROP) ? WD : WP;
                    frm_d       = '0;
                    state_d     = ACT;
                end
            end
            ACT: begin
                busy = 1'b1;
                if (!servo_EN) begin
                    width_req_d = WN;
                    state_d     = IDLE;
                end else if (frame_end) begin
                    if (frm_inc == ACT_LAST) begin
                        width_req_d = WN;
                        frm_d       = '0;
                        state_d     = RETURN;
                    end else begin
                        frm_d = frm_inc;
                    end
                end
            end
            RETURN: begin
                busy = 1'b1;
                if (!servo_EN) begin
                    width_req_d = WN;
                    state_d     = IDLE;
                end else if (frame_end) begin
                    if (frm_inc == RET_LAST) begin
                        state_d = DONE;
                    end else begin
                        frm_d = frm_inc;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                servo_done = 1'b1;
                state_d    = WAIT_REL;
            end
            WAIT_REL: begin
                // Hold off until the controller drops its request.
                if (!servo_EN) begin
                    state_d = IDLE;
                end
            end
            default: begin
                width_req_d = WN;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frm_q       <= '0;
            dir_q       <= PICK;
            width_req_q <= WN;
        end else begin
            state_q     <= state_d;
            frm_q       <= frm_d;
            dir_q       <= dir_d;
            width_req_q <= width_req_d;
        end
    end

endmodule

// File: doc/servo_sequencer.md
Name: servo_sequencer

Overview:
- Responder end of the rover's servo handshake: accepts the servo enable and pickup/dropoff select from the station flag controller.
- Drives the arm servo PWM through the chosen routine, then returns one-cycle servo_done to release the rover.
- Sits between the flag/state controller and the servo pin; holds the servo at neutral (90 deg) whenever idle.

Parameters:
- PERIOD_CYC, 2_000_000, clocks per PWM frame (20 ms at 100 MHz).
- W_NEUTRAL, 150_000, pulse width in clocks for neutral (1.5 ms, 90 deg).
- W_PICK, 100_000, pulse width for pickup position (1.0 ms).
- W_DROP, 200_000, pulse width for dropoff position (2.0 ms).
- ACT_FRAMES, 50, frames held at the target position.
- RET_FRAMES, 50, frames held at neutral before done.
- CNT_W, 21, width of the frame counter; must satisfy 2^CNT_W > PERIOD_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- servo_EN  in  1  level request; high = run the routine.
- servo_state  in  1  routine select: 0 = pickup, 1 = dropoff; sampled on acceptance only.
- pwm  out  1  servo control pulse.
- servo_done  out  1  one-cycle completion strobe.
- busy  out  1  high from acceptance until entry to WAIT_REL.

Behaviour:
- Reset (async, rst_n=0) values:
  - pwm=0, servo_done=0, busy=0.
  - FSM=IDLE, frame counter=0, frame count=0.
  - Latched direction=0; width_req=W_NEUTRAL; width_cur=W_NEUTRAL.
- PWM generator:
  - Counter runs 0..PERIOD_CYC-1 and wraps.
  - frame_end is high when the counter equals PERIOD_CYC-1.
  - width_cur loads width_req only on frame_end, so the width never changes mid-frame.
  - pwm is registered and is high for exactly width_cur cycles at the start of each frame.
  - The PWM runs continuously in every state, including IDLE.
- FSM states:
  - IDLE: width_req=W_NEUTRAL. If servo_EN=1, latch servo_state, set width_req to W_PICK (0) or W_DROP (1), clear frame count, assert busy, go to ACT. Acceptance can occur on any cycle, not only at a frame boundary.
  - ACT: increment frame count on each frame_end. When the count reaches ACT_FRAMES, set width_req=W_NEUTRAL, clear the count, go to RETURN.
  - RETURN: count frame_end strobes. When the count reaches RET_FRAMES, go to DONE.
  - DONE: servo_done=1 for exactly this one cycle; busy deasserts on exit; go to WAIT_REL.
  - WAIT_REL: stay until servo_EN=0, then go to IDLE. This prevents an immediate retrigger while the controller is still clearing servo_EN.
- Abort: if servo_EN=0 in ACT or RETURN, set width_req=W_NEUTRAL and go to IDLE. servo_done stays 0 and busy clears the next cycle.
- servo_state changes after acceptance are ignored.
- A first partial frame counts as a full frame, so ACT duration = ACT_FRAMES frames, -1 frame to +0 frames.
- Latency:
  - Target width appears at the first frame start after acceptance.
  - servo_done comes ACT_FRAMES+RET_FRAMES frame_ends after acceptance, +1 cycle.
- Reset mid-operation: immediate return to reset values; pwm drops at once.
- Widths are unsigned CNT_W bits; all W_* must be less than PERIOD_CYC (compile-time check).

Decomposition:
- Package servo_pkg:
  - FSM state enum: IDLE, ACT, RETURN, DONE, WAIT_REL.
  - Direction constants PICK=0, DROP=1.
  - Default width and period constants.
- One sub-module, servo_pwm_gen:
  - Contains the counter, width_cur register, frame_end strobe and pwm register.
  - Inputs: clk, rst_n, width_req. Outputs: pwm, frame_end.
- The sequencer FSM lives in servo_sequencer.

Test Plan (sim params PERIOD_CYC=100, W_NEUTRAL=15, W_PICK=10, W_DROP=20, ACT_FRAMES=3, RET_FRAMES=2):
1. Idle after reset, servo_EN=0 for 500 cycles -> pwm high exactly 15 cycles per 100; servo_done never asserts; busy=0.
2. servo_EN=1, servo_state=0 held until done -> next frame pwm width 10 for 3 frames, then width 15 for 2 frames; servo_done high exactly 1 cycle; busy falls after the strobe.
3. Same with servo_state=1, toggling servo_state to 0 mid-ACT -> width stays 20 for 3 frames (latched); done after 5 frames.
4. servo_EN held high for 300 cycles after servo_done -> no second routine; servo_EN low 1 cycle then high -> new routine starts.
5. servo_EN dropped during ACT frame 2 -> width returns to 15 at the next frame start; no servo_done; busy=0.
6. rst_n pulsed low mid-ACT -> pwm=0 and busy=0 immediately; after release, width 15 frames resume from counter 0.
